// File: rtl/run_ctrl.sv
// Run sequencer between the req/done handshake and the processor core.
// Holds the core in reset while idle, pulses reset on start, then runs it under a watchdog.
module run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 4096,
    parameter int PC_W       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             core_done,
    input  logic [PC_W-1:0]  prog_ctr,
    output logic             core_reset,
    output logic             core_run,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  last_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [3:0]  RST_LOAD  = 4'(RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);

    state_t           state_q, state_d;
    logic [3:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_q, timeout_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic             core_reset_q, core_reset_d;
    logic             core_run_q, core_run_d;
    logic             done_q, done_d;
    logic             wd_expire;

    // Saturating increment; the watchdog compares against the post-increment value.
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign wd_expire = (TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT_L);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        last_pc_d = last_pc_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_RST;
                    rst_cnt_d = RST_LOAD;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    last_pc_d = '0;
                end
            end
            S_RST: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (rst_cnt_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - 4'd1;
                end
            end
            S_RUN: begin
                // Abort beats a normal finish, which beats watchdog expiry.
                cnt_d = cnt_inc;
                if (!req) begin
                    state_d = S_IDLE;
                end else if (core_done) begin
                    state_d   = S_FIN;
                    last_pc_d = prog_ctr;
                end else if (wd_expire) begin
                    state_d   = S_FIN;
                    timeout_d = 1'b1;
                    last_pc_d = prog_ctr;
                end
            end
            S_FIN: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        core_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
        core_run_d   = (state_d == S_RUN);
        done_d       = (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= 4'd0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            last_pc_q    <= '0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            last_pc_q    <= last_pc_d;
            core_reset_q <= core_reset_d;
            core_run_q   <= core_run_d;
            done_q       <= done_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign core_run    = core_run_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;
    assign last_pc     = last_pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized scoreboard bench for run_ctrl: each run's outcome is predicted from
// the finish/abort/watchdog rules and checked by a monitor when core_run falls.
module tb_run_ctrl;

    localparam int RST_CYCLES = 2;
    localparam int CNT_W      = 16;
    localparam int TMO        = 16;
    localparam int PC_W       = 12;

    logic             clk;
    logic             reset;
    logic             req;
    logic             core_done;
    logic [PC_W-1:0]  prog_ctr;
    logic             core_reset;
    logic             core_run;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  last_pc;

    typedef struct packed {
        logic             done;
        logic             tmo;
        logic             core_rst;
        logic [CNT_W-1:0] cnt;
        logic [PC_W-1:0]  pc;
    } exp_t;

    exp_t exp_q[$];
    int   asserts  = 0;
    int   failures = 0;

    run_ctrl #(
        .RST_CYCLES(RST_CYCLES),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TMO),
        .PC_W      (PC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .core_done  (core_done),
        .prog_ctr   (prog_ctr),
        .core_reset (core_reset),
        .core_run   (core_run),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .last_pc    (last_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One complete run: predict the outcome, drive req/core_done/prog_ctr, then
    // hold in FIN for 'hold' cycles before releasing req. Starts and ends at a negedge.
    task automatic applyStimulus(input int done_at, input int abort_at, input int hold,
                                 input int pin_cycle, input logic [PC_W-1:0] pin_val);
        logic [PC_W-1:0] pcs [1:TMO];
        int   end_c;
        int   kind;
        exp_t e;
        for (int i = 1; i <= TMO; i++) pcs[i] = PC_W'($urandom);
        if (pin_cycle > 0) pcs[pin_cycle] = pin_val;

        end_c = TMO;
        kind  = 2;
        if (done_at != 0 && done_at <= end_c) begin
            end_c = done_at;
            kind  = 1;
        end
        if (abort_at != 0 && abort_at <= end_c) begin
            end_c = abort_at;
            kind  = 0;
        end
        e.done     = (kind != 0);
        e.tmo      = (kind == 2);
        e.core_rst = (kind == 0);
        e.cnt      = CNT_W'(end_c);
        e.pc       = (kind == 0) ? '0 : pcs[end_c];
        exp_q.push_back(e);

        req       = 1'b1;
        core_done = 1'($urandom);
        prog_ctr  = PC_W'($urandom);
        for (int r = 0; r < RST_CYCLES; r++) begin
            @(negedge clk);
            if (r == 0) begin
                checkOutput("start_clr_count", 32'(cycle_count), 32'd0);
                checkOutput("start_clr_pc", 32'(last_pc), 32'd0);
                checkOutput("start_clr_tmo", 32'(timeout), 32'd0);
            end
            checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
            checkOutput("rst_core_run", 32'(core_run), 32'd0);
            core_done = 1'($urandom);
        end
        for (int i = 1; i <= end_c; i++) begin
            @(negedge clk);
            checkOutput("run_core_run", 32'(core_run), 32'd1);
            checkOutput("run_core_reset", 32'(core_reset), 32'd0);
            checkOutput("run_count", 32'(cycle_count), 32'(i - 1));
            core_done = (i == done_at);
            req       = !(i == abort_at);
            prog_ctr  = pcs[i];
        end
        @(negedge clk);
        core_done = 1'($urandom);
        if (kind != 0) begin
            for (int h = 0; h < hold; h++) begin
                checkOutput("fin_done", 32'(done), 32'd1);
                checkOutput("fin_core_run", 32'(core_run), 32'd0);
                checkOutput("fin_count_held", 32'(cycle_count), 32'(end_c));
                checkOutput("fin_pc_held", 32'(last_pc), 32'(e.pc));
                core_done = 1'($urandom);
                prog_ctr  = PC_W'($urandom);
                @(negedge clk);
            end
            req = 1'b0;
            @(negedge clk);
        end
        checkOutput("idle_done_low", 32'(done), 32'd0);
        checkOutput("idle_core_reset", 32'(core_reset), 32'd1);
        checkOutput("idle_count_held", 32'(cycle_count), 32'(end_c));
        core_done = 1'b0;
    endtask

    // Monitor: every time the core stops running, pop the predicted result.
    initial begin
        logic prev_run;
        exp_t e;
        prev_run = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_run && !core_run) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_run_end", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_done", 32'(done), 32'(e.done));
                    checkOutput("sb_timeout", 32'(timeout), 32'(e.tmo));
                    checkOutput("sb_core_reset", 32'(core_reset), 32'(e.core_rst));
                    checkOutput("sb_cycle_count", 32'(cycle_count), 32'(e.cnt));
                    checkOutput("sb_last_pc", 32'(last_pc), 32'(e.pc));
                end
            end
            prev_run = core_run;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_time_limit: simulation did not end by itself");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        exp_t e;
        reset     = 1'b1;
        req       = 1'b0;
        core_done = 1'b0;
        prog_ctr  = '0;
        #3;
        checkOutput("reset_core_reset", 32'(core_reset), 32'd1);
        checkOutput("reset_core_run", 32'(core_run), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_timeout", 32'(timeout), 32'd0);
        checkOutput("reset_count", 32'(cycle_count), 32'd0);
        checkOutput("reset_last_pc", 32'(last_pc), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_req", 32'(core_reset), 32'd1);

        $display("[TB] directed runs");
        applyStimulus(10, 0, 1, 10, 12'h02A);
        applyStimulus(0, 0, 3, 0, '0);
        applyStimulus(16, 0, 2, 0, '0);
        applyStimulus(0, 5, 0, 0, '0);
        applyStimulus(7, 0, 20, 0, '0);
        applyStimulus(3, 0, 1, 0, '0);

        $display("[TB] asynchronous reset in the middle of a run");
        e = '{done: 1'b0, tmo: 1'b0, core_rst: 1'b1, cnt: '0, pc: '0};
        exp_q.push_back(e);
        req = 1'b1;
        for (int i = 0; i < RST_CYCLES + 3; i++) @(negedge clk);
        prog_ctr = 12'h155;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrun_reset_core_reset", 32'(core_reset), 32'd1);
        checkOutput("midrun_reset_core_run", 32'(core_run), 32'd0);
        checkOutput("midrun_reset_count", 32'(cycle_count), 32'd0);
        checkOutput("midrun_reset_done", 32'(done), 32'd0);
        #1;
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_reset_idle", 32'(core_reset), 32'd1);
        checkOutput("post_reset_run", 32'(core_run), 32'd0);

        $display("[TB] randomized runs");
        for (int n = 0; n < 40; n++) begin
            int d_at;
            int a_at;
            d_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
            a_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 0;
            applyStimulus(d_at, a_at, int'($urandom_range(0, 4)), 0, '0);
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
